// File: rtl/mem_arbiter_pkg.sv
// ============================================================================
// Module : mem_arbiter_pkg
// Brief  : Shared types for the system RAM arbiter (states, port ids, tags).
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package mem_arbiter_pkg;

    localparam int WORD_W = 8;

    typedef logic [WORD_W-1:0] word_t;

    typedef enum logic {
        ARB  = 1'b0,
        LOCK = 1'b1
    } e_arb_state;

    typedef enum logic {
        PORT_CPU = 1'b0,
        PORT_DMA = 1'b1
    } e_arb_port;

    typedef struct packed {
        logic      valid;
        e_arb_port port;
    } rd_tag_t;

    function automatic logic [15:0] sat_inc16(input logic [15:0] val, input logic en);
        logic [15:0] res;
        res = val;
        if (en && (val != 16'hFFFF)) begin
            res = val + 16'd1;
        end
        return res;
    endfunction

endpackage

`default_nettype wire

// File: rtl/mem_arbiter_starve_cnt.sv
// ============================================================================
// Module : mem_arbiter_starve_cnt
// Brief  : Saturating wait counter; flags when the wait reaches MAX cycles.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module mem_arbiter_starve_cnt #(
    parameter int MAX   = 4,
    parameter int CNT_W = $clog2(MAX + 1)
) (
    input  logic clk,
    input  logic rst,
    input  logic i_inc,
    input  logic i_clr,
    output logic o_at_max
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (i_clr) begin
            cnt_d = '0;
        end else if (i_inc && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign o_at_max = (cnt_q == CNT_MAX);

endmodule

`default_nettype wire

// File: rtl/mem_arbiter.sv
// ============================================================================
// Module : mem_arbiter
// Brief  : Single-port RAM arbiter between CPU (port 0) and loader/DMA (port 1)
//          with starvation forcing and port-1 burst lock.
// Config : MEM_ARB_STATS_EN adds stat_conflict / stat_p1_wait counters.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int ADDR_W     = 8,
    parameter int DATA_W     = 8,
    parameter int STARVE_MAX = 4,
    parameter int BURST_MAX  = 8
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              p0_req,
    input  logic              p0_we,
    input  logic [ADDR_W-1:0] p0_addr,
    input  logic [DATA_W-1:0] p0_wdata,
    output logic              p0_gnt,
    output logic              p0_rvalid,
    output logic [DATA_W-1:0] p0_rdata,

    input  logic              p1_req,
    input  logic              p1_we,
    input  logic [ADDR_W-1:0] p1_addr,
    input  logic [DATA_W-1:0] p1_wdata,
    input  logic              p1_lock,
    output logic              p1_gnt,
    output logic              p1_rvalid,
    output logic [DATA_W-1:0] p1_rdata,

    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_wr_en,
    output logic [DATA_W-1:0] mem_wr_data,
    input  logic [DATA_W-1:0] mem_rd_data,

    output logic              p0_stall
`ifdef MEM_ARB_STATS_EN
    ,
    output logic [15:0]       stat_conflict,
    output logic [15:0]       stat_p1_wait
`endif
);

    localparam int                 BURST_W   = $clog2(BURST_MAX + 1);
    localparam logic [BURST_W-1:0] BURST_LIM = BURST_W'(BURST_MAX);

    e_arb_state        state_q;
    e_arb_state        state_d;
    logic [BURST_W-1:0] burst_q;
    logic [BURST_W-1:0] burst_d;
    rd_tag_t           tag_q;
    rd_tag_t           tag_d;
    logic [ADDR_W-1:0] addr_q;
    logic [ADDR_W-1:0] addr_d;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] wdata_d;

    logic gnt0_raw;
    logic gnt1_raw;
    logic gnt0;
    logic gnt1;
    logic p1_starved;

    mem_arbiter_starve_cnt #(
        .MAX (STARVE_MAX)
    ) u_starve (
        .clk      (clk),
        .rst      (rst),
        .i_inc    (p1_req & ~gnt1),
        .i_clr    (gnt1 | ~p1_req),
        .o_at_max (p1_starved)
    );

    // Leaving LOCK hands the exit cycle to port 0 only, so a held lock can
    // never exceed BURST_MAX back-to-back port 1 grants.
    always_comb begin
        state_d  = state_q;
        burst_d  = burst_q;
        gnt0_raw = 1'b0;
        gnt1_raw = 1'b0;
        case (state_q)
            ARB: begin
                if (p0_req && !p1_starved) begin
                    gnt0_raw = 1'b1;
                end else if (p1_req) begin
                    gnt1_raw = 1'b1;
                    if (p1_lock) begin
                        state_d = LOCK;
                        burst_d = BURST_W'(1);
                    end
                end
            end
            LOCK: begin
                if (p1_req && p1_lock && (burst_q < BURST_LIM)) begin
                    gnt1_raw = 1'b1;
                    burst_d  = burst_q + BURST_W'(1);
                end else begin
                    gnt0_raw = p0_req;
                    state_d  = ARB;
                    burst_d  = '0;
                end
            end
            default: begin
                state_d = ARB;
                burst_d = '0;
            end
        endcase
    end

    // Grants are combinational, so they are held off while reset is asserted.
    assign gnt0 = gnt0_raw & rst;
    assign gnt1 = gnt1_raw & rst;

    always_comb begin
        mem_addr    = addr_q;
        mem_wr_data = wdata_q;
        mem_wr_en   = 1'b0;
        if (gnt1) begin
            mem_addr    = p1_addr;
            mem_wr_data = p1_wdata;
            mem_wr_en   = p1_we;
        end else if (gnt0) begin
            mem_addr    = p0_addr;
            mem_wr_data = p0_wdata;
            mem_wr_en   = p0_we;
        end
        addr_d      = mem_addr;
        wdata_d     = mem_wr_data;
        tag_d.valid = (gnt0 & ~p0_we) | (gnt1 & ~p1_we);
        tag_d.port  = gnt1 ? PORT_DMA : PORT_CPU;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ARB;
            burst_q <= '0;
            tag_q   <= '{valid: 1'b0, port: PORT_CPU};
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            burst_q <= burst_d;
            tag_q   <= tag_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
        end
    end

    assign p0_gnt    = gnt0;
    assign p1_gnt    = gnt1;
    assign p0_rvalid = tag_q.valid & (tag_q.port == PORT_CPU);
    assign p1_rvalid = tag_q.valid & (tag_q.port == PORT_DMA);
    assign p0_rdata  = p0_rvalid ? mem_rd_data : '0;
    assign p1_rdata  = p1_rvalid ? mem_rd_data : '0;
    assign p0_stall  = p0_req & ~gnt0 & rst;

`ifdef MEM_ARB_STATS_EN
    logic [15:0] conflict_q;
    logic [15:0] conflict_d;
    logic [15:0] p1_wait_q;
    logic [15:0] p1_wait_d;

    always_comb begin
        conflict_d = sat_inc16(conflict_q, p0_req & p1_req);
        p1_wait_d  = sat_inc16(p1_wait_q, p1_req & ~gnt1);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            conflict_q <= '0;
            p1_wait_q  <= '0;
        end else begin
            conflict_q <= conflict_d;
            p1_wait_q  <= p1_wait_d;
        end
    end

    assign stat_conflict = conflict_q;
    assign stat_p1_wait  = p1_wait_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_mem_arbiter.sv
// ============================================================================
// Module : tb_mem_arbiter
// Brief  : Randomized self-checking bench for mem_arbiter against a
//          cycle-level behavioural model of the arbitration rules.
// Config : MEM_ARB_STATS_EN enables the statistics counter checks.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_mem_arbiter;

    localparam int STARVE_MAX = 4;
    localparam int BURST_MAX  = 8;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       p0_req = 1'b0, p0_we = 1'b0, p1_req = 1'b0, p1_we = 1'b0, p1_lock = 1'b0;
    logic [7:0] p0_addr = '0, p0_wdata = '0, p1_addr = '0, p1_wdata = '0;
    logic       p0_gnt, p0_rvalid, p1_gnt, p1_rvalid, mem_wr_en, p0_stall;
    logic [7:0] p0_rdata, p1_rdata, mem_addr, mem_wr_data;
    logic [7:0] mem_rd_data = '0;
`ifdef MEM_ARB_STATS_EN
    logic [15:0] stat_conflict, stat_p1_wait;
`endif

    always #5 clk = ~clk;

    mem_arbiter dut (
        .clk(clk), .rst(rst),
        .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
        .p0_gnt(p0_gnt), .p0_rvalid(p0_rvalid), .p0_rdata(p0_rdata),
        .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
        .p1_lock(p1_lock), .p1_gnt(p1_gnt), .p1_rvalid(p1_rvalid), .p1_rdata(p1_rdata),
        .mem_addr(mem_addr), .mem_wr_en(mem_wr_en), .mem_wr_data(mem_wr_data),
        .mem_rd_data(mem_rd_data), .p0_stall(p0_stall)
`ifdef MEM_ARB_STATS_EN
        , .stat_conflict(stat_conflict), .stat_p1_wait(stat_p1_wait)
`endif
    );

    // Registered-read RAM; the RAM-side strobes are captured mid-cycle.
    logic [7:0] ram     [0:255];
    logic [7:0] ref_mem [0:255];
    logic       s_we;
    logic [7:0] s_addr, s_wd;

    always @(negedge clk) begin
        s_we   = mem_wr_en;
        s_addr = mem_addr;
        s_wd   = mem_wr_data;
    end

    always @(posedge clk) begin
        if (s_we) ram[s_addr] <= s_wd;
        mem_rd_data <= ram[s_addr];
    end

    int n_chk = 0;
    int n_err = 0;

    // Reference model state, counted in plain cycles
    int         m_wait  = 0;
    int         m_burst = 0;
    bit         m_pend_v = 1'b0;
    bit         m_pend_p = 1'b0;
    logic [7:0] m_pend_d = '0;
    logic [7:0] m_last_addr = '0;
    bit         obs_g1 = 1'b0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_wait = 0; m_burst = 0; m_pend_v = 1'b0; m_pend_p = 1'b0; m_last_addr = '0;
    endtask

    task automatic step(input bit r0, input bit w0, input logic [7:0] a0, input logic [7:0] d0,
                        input bit r1, input bit w1, input logic [7:0] a1, input logic [7:0] d1,
                        input bit lk, output bit g0, output bit g1);
        logic [7:0] ea;
        bit         ewe;
        p0_req = r0; p0_we = w0; p0_addr = a0; p0_wdata = d0;
        p1_req = r1; p1_we = w1; p1_addr = a1; p1_wdata = d1; p1_lock = r1 & lk;
        g0 = 1'b0;
        g1 = 1'b0;
        if (m_burst > 0) begin
            if (r1 && lk && m_burst < BURST_MAX) g1 = 1'b1;
            else g0 = r0;
        end else if (r0 && m_wait < STARVE_MAX) begin
            g0 = 1'b1;
        end else if (r1) begin
            g1 = 1'b1;
        end
        ea  = g1 ? a1 : (g0 ? a0 : m_last_addr);
        ewe = (g0 && w0) || (g1 && w1);
        @(negedge clk);
        obs_g1 = p1_gnt;
        check_val("p0_gnt", 32'(p0_gnt), 32'(g0));
        check_val("p1_gnt", 32'(p1_gnt), 32'(g1));
        check_val("p0_stall", 32'(p0_stall), 32'(r0 && !g0));
        check_val("mem_wr_en", 32'(mem_wr_en), 32'(ewe));
        check_val("mem_addr", 32'(mem_addr), 32'(ea));
        if (ewe) check_val("mem_wr_data", 32'(mem_wr_data), 32'(g1 ? d1 : d0));
        check_val("p0_rvalid", 32'(p0_rvalid), 32'(m_pend_v && !m_pend_p));
        check_val("p1_rvalid", 32'(p1_rvalid), 32'(m_pend_v && m_pend_p));
        if (m_pend_v && !m_pend_p) check_val("p0_rdata", 32'(p0_rdata), 32'(m_pend_d));
        if (m_pend_v && m_pend_p)  check_val("p1_rdata", 32'(p1_rdata), 32'(m_pend_d));
        m_pend_v = (g0 && !w0) || (g1 && !w1);
        m_pend_p = g1;
        m_pend_d = ref_mem[ea];
        if (ewe) ref_mem[ea] = g1 ? d1 : d0;
        m_last_addr = ea;
        if (m_burst > 0) m_burst = g1 ? m_burst + 1 : 0;
        else if (g1 && lk) m_burst = 1;
        if (r1 && !g1) begin
            if (m_wait < STARVE_MAX) m_wait++;
        end else begin
            m_wait = 0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        bit g0, g1;
        for (int i = 0; i < n; i++) step(0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00, 0, g0, g1);
    endtask

    task automatic run_random(input int cycles, input int prob0, input int prob1, input int lock_pct);
        bit a0 = 1'b0, a1 = 1'b0, w0 = 1'b0, w1 = 1'b0, lk = 1'b0, g0, g1;
        logic [7:0] ad0 = '0, ad1 = '0, d0 = '0, d1 = '0;
        for (int c = 0; c < cycles; c++) begin
            if (c % 16 == 0) lk = ($urandom_range(0, 99) < lock_pct);
            if (!a0 && $urandom_range(0, 99) < prob0) begin
                a0 = 1'b1; w0 = 1'($urandom_range(0, 1));
                ad0 = 8'($urandom_range(0, 31)); d0 = 8'($urandom);
            end
            if (!a1 && $urandom_range(0, 99) < prob1) begin
                a1 = 1'b1; w1 = 1'($urandom_range(0, 1));
                ad1 = 8'($urandom_range(0, 31)); d1 = 8'($urandom);
            end
            step(a0, w0, ad0, d0, a1, w1, ad1, d1, lk, g0, g1);
            if (g0) a0 = 1'b0;
            if (g1) a1 = 1'b0;
        end
    endtask

    initial begin
        bit         g0, g1, a0, a1;
        int         k, first;
        logic [7:0] ad0, d0, ad1, d1;

        for (int i = 0; i < 256; i++) begin
            ram[i]     = 8'(i * 7 + 3);
            ref_mem[i] = 8'(i * 7 + 3);
        end

        // Reset state
        @(negedge clk);
        check_val("reset_outs", 32'({p0_gnt, p1_gnt, p0_rvalid, p1_rvalid, mem_wr_en, p0_stall}), 32'd0);
        check_val("reset_addr", 32'(mem_addr), 32'd0);
        check_val("reset_wdata", 32'(mem_wr_data), 32'd0);
`ifdef MEM_ARB_STATS_EN
        check_val("reset_stats", {stat_conflict, stat_p1_wait}, 32'd0);
`endif
        rst = 1'b1;
        @(posedge clk);
        #1;

        // Lone CPU read, then back-to-back reads from both ports
        step(1, 0, 8'h10, 8'h00, 0, 0, 8'h00, 8'h00, 0, g0, g1);
        idle(2);
        step(1, 0, 8'h05, 8'h00, 0, 0, 8'h00, 8'h00, 0, g0, g1);
        step(0, 0, 8'h00, 8'h00, 1, 0, 8'h06, 8'h00, 0, g0, g1);
        idle(2);

        // Both ports writing continuously: port 1 gets through on its 5th waiting cycle
        a0 = 1'b0; ad0 = '0; d0 = '0; first = 0;
        for (int c = 1; c <= 12; c++) begin
            if (!a0) begin a0 = 1'b1; ad0 = 8'($urandom_range(64, 95)); d0 = 8'($urandom); end
            step(a0, 1, ad0, d0, 1, 1, 8'(32'h70 + c), 8'(32'hC0 + c), 0, g0, g1);
            if (g0) a0 = 1'b0;
            if (obs_g1 && first == 0) first = c;
        end
        check_val("starve_first_p1", 32'(first), 32'd5);
        idle(1);

        // Locked burst of 10 writes to 0x20..0x29 under continuous CPU load
        a0 = 1'b0; k = 0;
        for (int c = 0; c < 80 && k < 10; c++) begin
            if (!a0) begin a0 = 1'b1; ad0 = 8'($urandom_range(0, 15)); d0 = 8'($urandom); end
            step(a0, 1, ad0, d0, 1, 1, 8'(32'h20 + k), 8'(32'hA0 + k), 1, g0, g1);
            if (g0) a0 = 1'b0;
            if (g1) k++;
        end
        check_val("burst_done", 32'(k), 32'd10);
        for (int i = 0; i < 10; i++) step(1, 0, 8'(32'h20 + i), 8'h00, 0, 0, 8'h00, 8'h00, 0, g0, g1);
        idle(1);

        // Randomized load profiles
        run_random(300, 30, 30, 0);
        run_random(300, 100, 100, 0);
        run_random(300, 100, 100, 80);
        run_random(300, 60, 70, 40);
        idle(2);

        // Reset while a locked port 1 read is in flight
        p0_req = 1'b0; p1_req = 1'b1; p1_we = 1'b0; p1_addr = 8'h33; p1_lock = 1'b1;
        @(negedge clk);
        check_val("rst_pre_gnt", 32'(p1_gnt), 32'd1);
        #1;
        rst = 1'b0;
        p0_req = 1'b1; p0_we = 1'b1; p0_addr = 8'h44; p0_wdata = 8'h99;
        #1;
        check_val("rst_low_outs", 32'({p0_gnt, p1_gnt, p0_rvalid, p1_rvalid, mem_wr_en, p0_stall}), 32'd0);
        check_val("rst_low_addr", 32'({mem_addr, mem_wr_data}), 32'd0);
        @(posedge clk);
        #1;
        check_val("rst_low_p1_rvalid", 32'(p1_rvalid), 32'd0);
        check_val("rst_low_outs2", 32'({p0_gnt, p1_gnt, mem_wr_en, p0_stall, mem_addr}), 32'd0);
        @(negedge clk);
        p0_req = 1'b0; p1_req = 1'b0; p1_lock = 1'b0;
        rst = 1'b1;
        model_reset();
        @(posedge clk);
        #1;
        step(1, 0, 8'h44, 8'h00, 1, 0, 8'h45, 8'h00, 1, g0, g1);
        idle(2);
        run_random(200, 50, 60, 50);
        idle(2);

`ifdef MEM_ARB_STATS_EN
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        model_reset();
        @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) step(1, 0, 8'(32'h50 + i), 8'h00, 1, 0, 8'h58, 8'h00, 0, g0, g1);
        idle(1);
        check_val("stat_conflict", 32'(stat_conflict), 32'd3);
        check_val("stat_p1_wait", 32'(stat_p1_wait), 32'd3);
        p0_req = 1'b1; p0_we = 1'b0; p1_req = 1'b1; p1_we = 1'b0; p1_lock = 1'b0;
        repeat (65540) @(posedge clk);
        #1;
        check_val("stat_conflict_sat", 32'(stat_conflict), 32'hFFFF);
        p0_req = 1'b0; p1_req = 1'b0;
        @(posedge clk);
        #1;
        check_val("stat_conflict_hold", 32'(stat_conflict), 32'hFFFF);
`endif

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

`default_nettype wire
